// File: rtl/conv_mac5.sv
// rtl/conv_mac5.sv - 5-tap signed multiply-accumulate unit, two-stage pipeline
module conv_mac5 #(
    parameter int DW   = 8,
    parameter int TAPS = 5,
    parameter int OW   = 2 * DW + 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [DW-1:0] in0,
    input  logic signed [DW-1:0] in1,
    input  logic signed [DW-1:0] in2,
    input  logic signed [DW-1:0] in3,
    input  logic signed [DW-1:0] in4,
    input  logic signed [DW-1:0] w0,
    input  logic signed [DW-1:0] w1,
    input  logic signed [DW-1:0] w2,
    input  logic signed [DW-1:0] w3,
    input  logic signed [DW-1:0] w4,
    output logic signed [OW-1:0] out,
    output logic                 out_vld
);

    logic signed [DW-1:0]   x [TAPS];
    logic signed [DW-1:0]   c [TAPS];
    logic signed [2*DW-1:0] p [TAPS];
    logic                   v1;
    logic signed [OW-1:0]   sum;

    assign x[0] = in0;
    assign x[1] = in1;
    assign x[2] = in2;
    assign x[3] = in3;
    assign x[4] = in4;
    assign c[0] = w0;
    assign c[1] = w1;
    assign c[2] = w2;
    assign c[3] = w3;
    assign c[4] = w4;

    // Products are sign-extended before summing so the adder tree never overflows.
    always_comb begin
        sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum = sum + {{(OW - 2 * DW){p[k][2*DW-1]}}, p[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                p[k] <= '0;
            end
            v1      <= 1'b0;
            out     <= '0;
            out_vld <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < TAPS; k++) begin
                p[k] <= x[k] * c[k];
            end
            v1      <= 1'b1;
            out     <= sum;
            out_vld <= v1;
        end
    end

endmodule

// File: tb/tb_conv_mac5.sv
// tb/tb_conv_mac5.sv - directed self-checking bench for conv_mac5
module tb_conv_mac5;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [7:0]  in_v [5];
    logic signed [7:0]  w_v  [5];
    logic signed [18:0] out;
    logic               out_vld;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    conv_mac5 dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .in0     (in_v[0]),
        .in1     (in_v[1]),
        .in2     (in_v[2]),
        .in3     (in_v[3]),
        .in4     (in_v[4]),
        .w0      (w_v[0]),
        .w1      (w_v[1]),
        .w2      (w_v[2]),
        .w3      (w_v[3]),
        .w4      (w_v[4]),
        .out     (out),
        .out_vld (out_vld)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input int iv, input int wv);
        for (int k = 0; k < 5; k++) begin
            in_v[k] = 8'(iv);
            w_v[k]  = 8'(wv);
        end
    endtask

    task automatic set_vec(input int i0, input int i1, input int i2, input int i3, input int i4,
                           input int c0, input int c1, input int c2, input int c3, input int c4);
        in_v[0] = 8'(i0); in_v[1] = 8'(i1); in_v[2] = 8'(i2); in_v[3] = 8'(i3); in_v[4] = 8'(i4);
        w_v[0]  = 8'(c0); w_v[1]  = 8'(c1); w_v[2]  = 8'(c2); w_v[3]  = 8'(c3); w_v[4]  = 8'(c4);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        set_all(127, 127);
        step();
        step();
        check("reset_out", out, 0);
        check("reset_vld", {31'd0, out_vld}, 0);

        // Release reset: valid needs two enabled edges.
        rst = 1'b0;
        step();
        check("rel_vld_edge1", {31'd0, out_vld}, 0);
        step();
        check("rel_vld_edge2", {31'd0, out_vld}, 1);
        check("pos_full", out, 80645);

        set_all(-128, -128);
        step();
        step();
        check("neg_neg", out, 81920);

        set_all(-128, 127);
        step();
        step();
        check("neg_pos", out, -81280);

        set_vec(1, 1, 1, 1, 1, 33, -25, 32, 44, -127);
        step();
        step();
        check("taps_ones", out, -43);

        set_vec(10, 20, 30, 40, 50, 33, -25, 32, 44, -127);
        step();
        step();
        check("taps_ramp", out, -3800);

        // Stall: A=15, B=-13, C=-1; junk vector (12500) presented while en=0.
        set_vec(1, 1, 1, 1, 1, 1, 2, 3, 4, 5);
        en = 1'b1; step();
        check("stall_e1", out, -3800);
        set_all(50, 50);
        en = 1'b0; step();
        check("stall_e2_hold", out, -3800);
        set_vec(2, 0, 0, 0, -3, 7, 1, 1, 1, 9);
        en = 1'b1; step();
        check("stall_e3_a", out, 15);
        set_all(50, 50);
        en = 1'b0; step();
        check("stall_e4_hold", out, 15);
        set_vec(100, -100, 0, 0, 1, 100, 100, 0, 0, -1);
        en = 1'b1; step();
        check("stall_e5_b", out, -13);
        step();
        check("stall_e6_c", out, -1);
        check("stall_vld", {31'd0, out_vld}, 1);

        // Mid-stream reset: vector worth 20 is in flight and must vanish.
        set_all(1, 1);
        step();
        set_all(2, 2);
        step();
        check("mid_pre", out, 5);
        rst = 1'b1;
        set_all(3, 1);
        step();
        check("mid_rst_out", out, 0);
        check("mid_rst_vld", {31'd0, out_vld}, 0);
        rst = 1'b0;
        step();
        check("mid_post1_out", out, 0);
        check("mid_post1_vld", {31'd0, out_vld}, 0);
        step();
        check("mid_post2_out", out, 15);
        check("mid_post2_vld", {31'd0, out_vld}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
